// File: rtl/line_read_extractor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : line_read_pkg
//  Purpose  : Shared constants and FSM state type for the line read extractor.
//             State STREAM exists only when LINE_STREAM_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
package line_read_pkg;

  localparam int LINE_BYTES = 8;
  localparam int BYTE_W     = 8;
  localparam int ADDR_W     = $clog2(LINE_BYTES);
  localparam int LINE_W     = LINE_BYTES * BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BYTE_OUT = 2'd1,
`ifdef LINE_STREAM_EN
    ST_LINE_OUT = 2'd2,
    ST_STREAM   = 2'd3
`else
    ST_LINE_OUT = 2'd2
`endif
  } state_t;

endpackage : line_read_pkg
`default_nettype wire

// File: rtl/line_read_extractor_if.sv
`default_nettype none
// ============================================================================
//  Module   : line_read_extractor_if
//  Purpose  : Request / response bundle between the load path (master) and
//             the line read extractor (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface line_read_extractor_if;
  import line_read_pkg::*;

  logic              Req;
  logic              LineOrByte;
  logic [ADDR_W-1:0] AddressLine;
  logic [LINE_W-1:0] LineData;
  logic              Ready;
  logic              Busy;
  logic [BYTE_W-1:0] ByteOut;
  logic              ByteValid;
  logic              ByteLast;
  logic [LINE_W-1:0] LineOut;
  logic              LineValid;

  modport master (
    output Req, LineOrByte, AddressLine, LineData, Ready,
    input  Busy, ByteOut, ByteValid, ByteLast, LineOut, LineValid
  );

  modport slave (
    input  Req, LineOrByte, AddressLine, LineData, Ready,
    output Busy, ByteOut, ByteValid, ByteLast, LineOut, LineValid
  );

endinterface : line_read_extractor_if
`default_nettype wire

// File: rtl/line_read_extractor_byte_mux.sv
`default_nettype none
// ============================================================================
//  Module   : line_byte_mux
//  Purpose  : Combinational 8:1 byte select from a captured cache line.
//  Revision : 1.0 - initial release
// ============================================================================
module line_byte_mux
  import line_read_pkg::*;
(
  input  wire logic [LINE_W-1:0] line_i,
  input  wire logic [ADDR_W-1:0] idx_i,
  output logic      [BYTE_W-1:0] byte_o
);

  // Byte 0 sits in the least significant lane of the line
  assign byte_o = line_i[idx_i*BYTE_W +: BYTE_W];

endmodule : line_byte_mux
`default_nettype wire

// File: rtl/line_read_extractor.sv
`default_nettype none
// ============================================================================
//  Module   : line_read_extractor
//  Purpose  : Captures a cache line on request and returns the addressed
//             byte or the whole line over a valid/ready handshake.
//             Optional macro LINE_STREAM_EN: line accesses are streamed as
//             eight byte beats, critical byte first, instead of one 64-bit beat.
//  Revision : 1.0 - initial release
// ============================================================================
module line_read_extractor
  import line_read_pkg::*;
(
  input  wire logic            CLK,
  input  wire logic            Clear,
  line_read_extractor_if.slave bus
);

  state_t            state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              byte_valid;
  logic              byte_last;
  logic              line_valid;
  logic [BYTE_W-1:0] sel_byte;

`ifdef LINE_STREAM_EN
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Beat counter for the streamed line; restarts on every accepted request
  always_ff @(posedge CLK) begin
    if (Clear) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  // State, captured line and byte pointer
  always_ff @(posedge CLK) begin
    if (Clear) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state and beat qualifiers; data is only captured in IDLE so later
  // LineData changes cannot disturb a pending beat
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    ptr_d      = ptr_q;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    line_valid = 1'b0;
`ifdef LINE_STREAM_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.Req) begin
          line_d = bus.LineData;
          ptr_d  = bus.AddressLine;
`ifdef LINE_STREAM_EN
          cnt_d   = '0;
          state_d = bus.LineOrByte ? ST_BYTE_OUT : ST_STREAM;
`else
          state_d = bus.LineOrByte ? ST_BYTE_OUT : ST_LINE_OUT;
`endif
        end
      end
      ST_BYTE_OUT: begin
        byte_valid = 1'b1;
        byte_last  = 1'b1;
        if (bus.Ready) state_d = ST_IDLE;
      end
      ST_LINE_OUT: begin
        line_valid = 1'b1;
        if (bus.Ready) state_d = ST_IDLE;
      end
`ifdef LINE_STREAM_EN
      ST_STREAM: begin
        byte_valid = 1'b1;
        byte_last  = (cnt_q == ADDR_W'(LINE_BYTES - 1));
        if (bus.Ready) begin
          ptr_d = ptr_q + 1'b1;   // natural wrap 7 -> 0
          cnt_d = cnt_q + 1'b1;
          if (byte_last) state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  line_byte_mux u_byte_mux (
    .line_i (line_q),
    .idx_i  (ptr_q),
    .byte_o (sel_byte)
  );

  // Outputs derive from registered state only; data lanes are zero when idle
  assign bus.Busy      = (state_q != ST_IDLE);
  assign bus.ByteValid = byte_valid;
  assign bus.ByteLast  = byte_last;
  assign bus.ByteOut   = byte_valid ? sel_byte : '0;
  assign bus.LineValid = line_valid;
  assign bus.LineOut   = line_valid ? line_q : '0;

endmodule : line_read_extractor
`default_nettype wire

// File: tb/tb_line_read_extractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_read_extractor
//  Purpose  : Directed self-checking bench for line_read_extractor.
//             Follows LINE_STREAM_EN to pick the line-read or stream scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_line_read_extractor;
  import line_read_pkg::*;

  localparam logic [63:0] PAT = 64'h8877_6655_4433_2211;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  line_read_extractor_if bus ();

  line_read_extractor dut (
    .CLK   (clk),
    .Clear (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Req = 1'b0; bus.LineOrByte = 1'b0; bus.AddressLine = '0;
    bus.LineData = '0; bus.Ready = 1'b0;
    step(); step();
    checks++;
    if ({bus.Busy, bus.ByteValid, bus.ByteLast, bus.LineValid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.Busy, bus.ByteValid, bus.ByteLast, bus.LineValid});
    end
    checks++;
    if (bus.ByteOut !== 8'h00 || bus.LineOut !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h want 0/0", bus.ByteOut, bus.LineOut);
    end
    rst = 1'b0;
  endtask

  task automatic test_byte_read();
    bus.LineData = PAT; bus.AddressLine = 3'd5; bus.LineOrByte = 1'b1;
    bus.Ready = 1'b1; bus.Req = 1'b1;
    step();
    bus.Req = 1'b0;
    checks++;
    if (bus.ByteOut !== 8'h66 || bus.ByteValid !== 1'b1 || bus.ByteLast !== 1'b1
        || bus.Busy !== 1'b1 || bus.LineValid !== 1'b0) begin
      errors++;
      $display("FAIL byte_read_beat: got out=%h v=%b l=%b busy=%b lv=%b want 66 1 1 1 0",
               bus.ByteOut, bus.ByteValid, bus.ByteLast, bus.Busy, bus.LineValid);
    end
    step();
    checks++;
    if (bus.Busy !== 1'b0 || bus.ByteValid !== 1'b0 || bus.ByteOut !== 8'h00) begin
      errors++;
      $display("FAIL byte_read_done: got busy=%b v=%b out=%h want 0 0 00",
               bus.Busy, bus.ByteValid, bus.ByteOut);
    end
  endtask

  task automatic test_backpressure();
    bus.LineData = PAT; bus.AddressLine = 3'd5; bus.LineOrByte = 1'b1;
    bus.Ready = 1'b0; bus.Req = 1'b1;
    step();
    bus.Req = 1'b0; bus.LineData = '0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.ByteOut !== 8'h66 || bus.ByteValid !== 1'b1 || bus.Busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold%0d: got out=%h v=%b busy=%b want 66 1 1",
                 i, bus.ByteOut, bus.ByteValid, bus.Busy);
      end
      step();
    end
    bus.Ready = 1'b1;
    checks++;
    if (bus.ByteOut !== 8'h66 || bus.ByteValid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_last: got out=%h v=%b want 66 1", bus.ByteOut, bus.ByteValid);
    end
    step();
    checks++;
    if (bus.Busy !== 1'b0 || bus.ByteValid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_done: got busy=%b v=%b want 0 0", bus.Busy, bus.ByteValid);
    end
  endtask

  task automatic test_back_to_back();
    // Req held high: a new read is accepted only on the idle cycle in between
    bus.LineData = PAT; bus.AddressLine = 3'd2; bus.LineOrByte = 1'b1;
    bus.Ready = 1'b1; bus.Req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (i % 2 == 0) begin
        if (bus.ByteValid !== 1'b1 || bus.ByteOut !== 8'h33) begin
          errors++;
          $display("FAIL b2b_beat%0d: got v=%b out=%h want 1 33", i, bus.ByteValid, bus.ByteOut);
        end
      end else begin
        if (bus.Busy !== 1'b0 || bus.ByteValid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_gap%0d: got busy=%b v=%b want 0 0", i, bus.Busy, bus.ByteValid);
        end
      end
    end
    bus.Req = 1'b0;
    step();
  endtask

  task automatic test_ready_idle();
    bus.Req = 1'b0; bus.Ready = 1'b1;
    step();
    checks++;
    if ({bus.Busy, bus.ByteValid, bus.LineValid} !== 3'b000 || bus.ByteOut !== 8'h00) begin
      errors++;
      $display("FAIL ready_idle: got busy/bv/lv=%b out=%h want 000 00",
               {bus.Busy, bus.ByteValid, bus.LineValid}, bus.ByteOut);
    end
  endtask

`ifdef LINE_STREAM_EN
  task automatic test_stream();
    logic [7:0] exp [8];
    exp = '{8'h77, 8'h88, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    bus.LineData = PAT; bus.AddressLine = 3'd6; bus.LineOrByte = 1'b0;
    bus.Ready = 1'b1; bus.Req = 1'b1;
    step();
    bus.Req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus.ByteValid !== 1'b1 || bus.ByteOut !== exp[k] || bus.ByteLast !== (k == 7)
          || bus.LineValid !== 1'b0) begin
        errors++;
        $display("FAIL stream_beat%0d: got v=%b out=%h last=%b lv=%b want 1 %h %b 0",
                 k, bus.ByteValid, bus.ByteOut, bus.ByteLast, bus.LineValid, exp[k], (k == 7));
      end
      step();
    end
    checks++;
    if (bus.Busy !== 1'b0 || bus.ByteValid !== 1'b0) begin
      errors++;
      $display("FAIL stream_done: got busy=%b v=%b want 0 0", bus.Busy, bus.ByteValid);
    end
  endtask

  task automatic test_clear_mid();
    bus.LineData = PAT; bus.AddressLine = 3'd6; bus.LineOrByte = 1'b0;
    bus.Ready = 1'b1; bus.Req = 1'b1;
    step();
    bus.Req = 1'b0;
    step(); step(); step();   // now presenting beat 3
    checks++;
    if (bus.ByteOut !== 8'h22 || bus.ByteValid !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre_beat3: got out=%h v=%b want 22 1", bus.ByteOut, bus.ByteValid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
`else
  task automatic test_line_read();
    bus.LineData = PAT; bus.AddressLine = 3'd3; bus.LineOrByte = 1'b0;
    bus.Ready = 1'b1; bus.Req = 1'b1;
    step();
    // Keep a byte request up during the line beat: it must be dropped
    bus.LineOrByte = 1'b1;
    checks++;
    if (bus.LineOut !== PAT || bus.LineValid !== 1'b1 || bus.ByteValid !== 1'b0
        || bus.ByteLast !== 1'b0 || bus.Busy !== 1'b1) begin
      errors++;
      $display("FAIL line_read_beat: got %h lv=%b bv=%b bl=%b busy=%b want %h 1 0 0 1",
               bus.LineOut, bus.LineValid, bus.ByteValid, bus.ByteLast, bus.Busy, PAT);
    end
    step();
    bus.Req = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0 || bus.LineValid !== 1'b0 || bus.LineOut !== 64'h0
        || bus.ByteValid !== 1'b0) begin
      errors++;
      $display("FAIL line_read_done: got busy=%b lv=%b out=%h bv=%b want 0 0 0 0",
               bus.Busy, bus.LineValid, bus.LineOut, bus.ByteValid);
    end
    step();
  endtask

  task automatic test_clear_mid();
    // Byte beat held pending by backpressure, then cleared
    bus.LineData = PAT; bus.AddressLine = 3'd4; bus.LineOrByte = 1'b1;
    bus.Ready = 1'b0; bus.Req = 1'b1;
    step();
    bus.Req = 1'b0;
    step();
    checks++;
    if (bus.ByteOut !== 8'h55 || bus.ByteValid !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre_beat: got out=%h v=%b want 55 1", bus.ByteOut, bus.ByteValid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif
    checks++;
    if ({bus.Busy, bus.ByteValid, bus.ByteLast, bus.LineValid} !== 4'b0000
        || bus.ByteOut !== 8'h00 || bus.LineOut !== 64'h0) begin
      errors++;
      $display("FAIL clear_mid_outputs: got flags=%b byte=%h line=%h want 0000 00 0",
               {bus.Busy, bus.ByteValid, bus.ByteLast, bus.LineValid}, bus.ByteOut, bus.LineOut);
    end
    bus.LineData = PAT; bus.AddressLine = 3'd0; bus.LineOrByte = 1'b1;
    bus.Ready = 1'b1; bus.Req = 1'b1;
    step();
    bus.Req = 1'b0;
    checks++;
    if (bus.ByteOut !== 8'h11 || bus.ByteValid !== 1'b1) begin
      errors++;
      $display("FAIL clear_fresh_read: got out=%h v=%b want 11 1", bus.ByteOut, bus.ByteValid);
    end
    step();
  endtask

  task automatic test_clear_with_req();
    bus.LineData = PAT; bus.AddressLine = 3'd1; bus.LineOrByte = 1'b1;
    bus.Ready = 1'b1; bus.Req = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; bus.Req = 1'b0;
    checks++;
    if ({bus.Busy, bus.ByteValid, bus.LineValid} !== 3'b000) begin
      errors++;
      $display("FAIL clear_req_first: got busy/bv/lv=%b want 000",
               {bus.Busy, bus.ByteValid, bus.LineValid});
    end
    step();
    checks++;
    if ({bus.Busy, bus.ByteValid, bus.LineValid} !== 3'b000 || bus.ByteOut !== 8'h00) begin
      errors++;
      $display("FAIL clear_req_after: got busy/bv/lv=%b out=%h want 000 00",
               {bus.Busy, bus.ByteValid, bus.LineValid}, bus.ByteOut);
    end
  endtask

  initial begin
    test_reset();
    test_byte_read();
    test_backpressure();
    test_back_to_back();
    test_ready_idle();
`ifdef LINE_STREAM_EN
    test_stream();
`else
    test_line_read();
`endif
    test_clear_mid();
    test_clear_with_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_line_read_extractor
`default_nettype wire

// File: doc/line_read_extractor.md
# line_read_extractor

Read-side counterpart of the cache-line byte/line write merge logic. Captures a 64-bit cache line on request and returns either the single addressed byte or the whole line to the consumer over a valid/ready handshake. Sits between the cache data register bank and the processor load path. Optional critical-byte-first streaming of a full line over eight byte beats.

## Interface
- `LINE_BYTES`, 8, bytes per line; `ADDR_W` = $clog2(LINE_BYTES)
- `BYTE_W`, 8, bits per byte; line width = LINE_BYTES*BYTE_W (64)
- `CLK` in 1: single clock, rising edge
- `Clear` in 1: reset, synchronous, active-high
- `Req` in 1: read request, sampled only when `Busy`=0
- `LineOrByte` in 1: 1 = byte access, 0 = line access; sampled with `Req`
- `AddressLine` in ADDR_W: byte index within line; sampled with `Req`
- `LineData` in 64: line from register bank; sampled with `Req`
- `Ready` in 1: consumer accepts current beat
- `Busy` out 1: request in flight, new `Req` ignored
- `ByteOut` out BYTE_W: byte data
- `ByteValid` out 1: `ByteOut` valid
- `ByteLast` out 1: final byte beat (streaming only; else equals `ByteValid`)
- `LineOut` out 64: line data
- `LineValid` out 1: `LineOut` valid

## Operation
- States: IDLE, BYTE_OUT, LINE_OUT, STREAM (STREAM exists only with `LINE_STREAM_EN`).
- IDLE, `Req`=1: capture `LineData` into line register, `AddressLine` into pointer, clear beat counter; go BYTE_OUT if `LineOrByte`=1, else LINE_OUT (or STREAM when compiled in).
- BYTE_OUT: `ByteOut` = captured byte [pointer], `ByteValid`=`ByteLast`=1; on `Ready` -> IDLE.
- LINE_OUT: `LineOut` = captured line, `LineValid`=1; on `Ready` -> IDLE.
- STREAM: beat k (k=0..7) drives byte (pointer+k) mod 8; pointer increments with wrap 7->0 on each `ByteValid`&&`Ready`; `ByteLast`=1 on k=7; handshake on k=7 -> IDLE.
- Output data held stable while valid and `Ready`=0; later `LineData` changes have no effect.
- `Busy` = (state != IDLE). `Req` while `Busy`=1 dropped, not queued.
- Invalid outputs driven to zero (`ByteOut`, `LineOut` = 0 when respective valid is 0).
- `Ready` with no valid asserted: ignored.

## Timing
- Reset: all outputs 0, state IDLE, line register/pointer/counter 0.
- `Req` accepted in cycle N -> first valid beat in cycle N+1 (1-cycle latency, registered outputs).
- Final handshake in cycle M -> `Busy`=0 in M+1; next `Req` accepted at earliest in M+1 (no same-cycle re-arm).
- Minimum throughput: byte/line read every 2 cycles; stream 8 beats in 8 cycles with `Ready` held high.
- `Clear` in any state, including mid-stream or with a beat pending: next cycle all outputs 0, state IDLE; in-flight read discarded; `Clear` wins over simultaneous `Req`.

## Configuration
- `LINE_STREAM_EN` defined: line access (`LineOrByte`=0) enters STREAM, emits eight byte beats critical-byte-first on `ByteOut`; `LineValid` never asserts.
- Not defined: line access enters LINE_OUT, single 64-bit beat on `LineOut`; `ByteLast` = `ByteValid`; no beat counter synthesized.

## Structure
- Package `line_read_pkg`: state enum, `LINE_BYTES`, `BYTE_W`, `ADDR_W`, `LINE_W` constants.
- Sub-module `line_byte_mux`: combinational 8:1 byte select (line, index -> byte); shared by BYTE_OUT and STREAM paths.
- FSM, line register, pointer, counter in top level.

## Test plan
- Byte read: `LineData`=64'h8877_6655_4433_2211, `AddressLine`=5, `LineOrByte`=1, `Ready`=1 -> cycle N+1 `ByteOut`=8'h66, `ByteValid`=`ByteLast`=1; `Busy`=0 at N+2.
- Backpressure: same read, `Ready`=0 for 3 cycles, `LineData` changed to 0 after capture -> `ByteOut` stays 8'h66, valid held; completes on first `Ready`.
- Line read (macro off): `LineOrByte`=0 -> N+1 `LineOut`=64'h8877_6655_4433_2211, `LineValid`=1 one beat; `Req` during it ignored.
- Stream (macro on): `AddressLine`=6, `Ready`=1 -> `ByteOut` sequence 77,88,11,22,33,44,55,66; `ByteLast` only on 8th beat; `Busy` drops next cycle.
- Clear mid-stream: assert `Clear` on beat 3 -> next cycle all outputs 0, `Busy`=0; fresh byte `Req` (addr 0) returns 8'h11.
- Reset with simultaneous `Req`: `Clear`=`Req`=1 -> no valid beat follows; state IDLE.
